// File: rtl/mux_glitch_monitor_pkg.sv
// Shared types, default parameters and helpers for the mux glitch monitor.
package mux_glitch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WINDOW,
    STABLE,
    DONE
  } mon_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_SETTLE_CYC  = 8;
  localparam int DEF_STABLE_CYC  = 3;
  localparam int DEF_TIMEOUT_CYC = 64;
  localparam int DEF_CNT_W       = 4;
  localparam int GTOT_W          = 16;

  // A logical change of the mux output needs exactly one transition; a hold needs none.
  function automatic logic required_trans(input logic init_v, input logic final_v);
    return init_v ^ final_v;
  endfunction

endpackage

// File: rtl/mux_glitch_monitor_if.sv
// Sequencer-facing start/result bundle of the mux glitch monitor.
interface mux_glitch_monitor_if
  import mux_glitch_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic              eval_start;
  logic              exp_val;
  logic              busy;
  logic              done;
  logic              final_val;
  logic [CNT_W-1:0]  trans_cnt;
  logic              glitch;
  logic              mismatch;
  logic              timeout;
  logic [GTOT_W-1:0] glitch_total;

  modport master (
    output eval_start, exp_val,
    input  busy, done, final_val, trans_cnt, glitch, mismatch, timeout, glitch_total
  );

  modport slave (
    input  eval_start, exp_val,
    output busy, done, final_val, trans_cnt, glitch, mismatch, timeout, glitch_total
  );
endinterface

// File: rtl/mux_glitch_monitor_bit_sync.sv
// N-flop synchroniser for a single asynchronous gadget output.
module bit_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[N-2:0], d};
  end

  assign q = chain[N-1];

endmodule

// File: rtl/mux_glitch_monitor.sv
// Observes the synchronised mux output after each input change: counts transitions,
// waits for stability (or times out) and reports value, glitch and mismatch.
//
// state  | meaning
// IDLE   | waiting for eval_start; results held
// WINDOW | fixed SETTLE_CYC observation window, counting edges
// STABLE | waiting for STABLE_CYC edge-free cycles, bounded by TIMEOUT_CYC
// DONE   | one-cycle result pulse
module mux_glitch_monitor
  import mux_glitch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mux_in,
  mux_glitch_monitor_if.slave  bus
);

  localparam int TMR_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int STB_W   = $clog2(STABLE_CYC + 1);

  mon_state_e        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [STB_W-1:0]  stb_q, stb_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d, tcnt_inc;
  logic              exp_q, exp_d;
  logic              init_q, init_d;
  logic              tout_q, tout_d;
  logic              glitch_q, glitch_d;
  logic              mism_q, mism_d;
  logic              final_q, final_d;
  logic [GTOT_W-1:0] gtot_q, gtot_d;
  logic              s, prev_q, edge_seen;
  logic              glitch_now, mism_now;
  logic              settle_hit, tmo_hit;

  bit_sync #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mux_in),
    .q     (s)
  );

  assign edge_seen  = s ^ prev_q;
  assign tcnt_inc   = (tcnt_q == '1) ? tcnt_q : tcnt_q + CNT_W'(1);
  assign glitch_now = (tcnt_q > CNT_W'(required_trans(init_q, s))) | tout_q;
  assign mism_now   = s ^ exp_q;
  assign settle_hit = !edge_seen && (stb_q == STB_W'(STABLE_CYC - 1));
  assign tmo_hit    = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stb_d    = stb_q;
    tcnt_d   = tcnt_q;
    exp_d    = exp_q;
    init_d   = init_q;
    tout_d   = tout_q;
    glitch_d = glitch_q;
    mism_d   = mism_q;
    final_d  = final_q;
    gtot_d   = gtot_q;
    case (state_q)
      IDLE: begin
        if (bus.eval_start) begin
          exp_d    = bus.exp_val;
          init_d   = s;
          tcnt_d   = '0;
          timer_d  = '0;
          stb_d    = '0;
          glitch_d = 1'b0;
          mism_d   = 1'b0;
          tout_d   = 1'b0;
          state_d  = WINDOW;
        end
      end
      WINDOW: begin
        timer_d = timer_q + TMR_W'(1);
        if (edge_seen) tcnt_d = tcnt_inc;
        if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
          timer_d = '0;
          stb_d   = '0;
          state_d = STABLE;
        end
      end
      STABLE: begin
        timer_d = timer_q + TMR_W'(1);
        if (edge_seen) begin
          tcnt_d = tcnt_inc;
          stb_d  = '0;
        end else begin
          stb_d  = stb_q + STB_W'(1);
        end
        // A settle in the same cycle as the timeout takes priority.
        if (settle_hit) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          tout_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        final_d  = s;
        glitch_d = glitch_now;
        mism_d   = mism_now;
        if (glitch_now && gtot_q != '1) gtot_d = gtot_q + GTOT_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      stb_q    <= '0;
      tcnt_q   <= '0;
      exp_q    <= 1'b0;
      init_q   <= 1'b0;
      tout_q   <= 1'b0;
      glitch_q <= 1'b0;
      mism_q   <= 1'b0;
      final_q  <= 1'b0;
      gtot_q   <= '0;
      prev_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      stb_q    <= stb_d;
      tcnt_q   <= tcnt_d;
      exp_q    <= exp_d;
      init_q   <= init_d;
      tout_q   <= tout_d;
      glitch_q <= glitch_d;
      mism_q   <= mism_d;
      final_q  <= final_d;
      gtot_q   <= gtot_d;
      prev_q   <= s;
    end
  end

  // Results are live during the DONE pulse and held from the registers afterwards.
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.final_val    = (state_q == DONE) ? s          : final_q;
  assign bus.glitch       = (state_q == DONE) ? glitch_now : glitch_q;
  assign bus.mismatch     = (state_q == DONE) ? mism_now   : mism_q;
  assign bus.trans_cnt    = tcnt_q;
  assign bus.timeout      = tout_q;
  assign bus.glitch_total = gtot_q;

endmodule
